// File: rtl/kernel_2mm_core_if.sv
// Scratchpad access bundle between the 2mm kernel (master) and the host-side memory wrapper (slave).
// ce=1 issues one access that cycle; we=1 with ce=1 writes d on that edge; ce=1, we=0 returns q on the next edge.
interface kernel_2mm_core_if #(
  parameter int AW = 14
);
  logic [AW-1:0] address0;
  logic          ce0;
  logic          we0;
  logic [31:0]   d0;
  logic [31:0]   q0;
  logic [AW-1:0] address1;
  logic          ce1;
  logic          we1;
  logic [31:0]   d1;
  logic [31:0]   q1;

  modport master (
    output address0, ce0, we0, d0, address1, ce1, we1, d1,
    input  q0, q1
  );

  modport slave (
    input  address0, ce0, we0, d0, address1, ce1, we1, d1,
    output q0, q1
  );
endinterface

// File: rtl/kernel_2mm_core.sv
// Integer 2mm kernel: tmp = ALPHA*A*B, then D = tmp*C + BETA*D, in place on a shared scratchpad.
// Started and finished through ap_ctrl_hs; all writes go through port 0.
module kernel_2mm_core #(
  parameter int                 NI    = 16,
  parameter int                 NK    = 16,
  parameter int                 NJ    = 16,
  parameter int                 NL    = 16,
  parameter logic signed [31:0] ALPHA = 32'sd3,
  parameter logic signed [31:0] BETA  = 32'sd2,
  parameter int                 AW    = 14
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [3:0]        state_dbg,
  kernel_2mm_core_if.master indata
);

  localparam logic [AW-1:0] A_BASE = '0;
  localparam logic [AW-1:0] B_BASE = AW'(NI * NK);
  localparam logic [AW-1:0] T_BASE = AW'(NI * NK + NK * NJ);
  localparam logic [AW-1:0] C_BASE = AW'(NI * NK + NK * NJ + NI * NJ);
  localparam logic [AW-1:0] D_BASE = AW'(NI * NK + NK * NJ + NI * NJ + NJ * NL);
  localparam logic [AW-1:0] NK_W   = AW'(NK);
  localparam logic [AW-1:0] NJ_W   = AW'(NJ);
  localparam logic [AW-1:0] NL_W   = AW'(NL);
  localparam logic [AW-1:0] NI_L   = AW'(NI - 1);
  localparam logic [AW-1:0] NK_L   = AW'(NK - 1);
  localparam logic [AW-1:0] NJ_L   = AW'(NJ - 1);
  localparam logic [AW-1:0] NL_L   = AW'(NL - 1);
  localparam logic [31:0]   ALPHA_W = ALPHA;
  localparam logic [31:0]   BETA_W  = BETA;

  typedef enum logic [3:0] {
    IDLE, P1_CLR, P1_RD, P1_MAC, P1_WR,
    P2_RDD, P2_SCL, P2_RD, P2_MAC, P2_WR, FIN
  } state_t;

  state_t        state, next;
  logic [AW-1:0] i, j, k;
  logic [31:0]   acc;

  assign state_dbg = state;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= next;
  end

  // Outputs depend only on state and counters, so IDLE (and reset) drives every port low.
  always_comb begin
    next            = state;
    ap_idle         = 1'b0;
    ap_done         = 1'b0;
    ap_ready        = 1'b0;
    indata.address0 = '0;
    indata.ce0      = 1'b0;
    indata.we0      = 1'b0;
    indata.d0       = '0;
    indata.address1 = '0;
    indata.ce1      = 1'b0;
    indata.we1      = 1'b0;
    indata.d1       = '0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) next = P1_CLR;
      end
      P1_CLR: next = P1_RD;
      P1_RD: begin
        indata.ce0      = 1'b1;
        indata.address0 = A_BASE + i * NK_W + k;
        indata.ce1      = 1'b1;
        indata.address1 = B_BASE + k * NJ_W + j;
        next            = P1_MAC;
      end
      P1_MAC: next = (k == NK_L) ? P1_WR : P1_RD;
      P1_WR: begin
        indata.ce0      = 1'b1;
        indata.we0      = 1'b1;
        indata.address0 = T_BASE + i * NJ_W + j;
        indata.d0       = acc;
        next            = (i == NI_L && j == NJ_L) ? P2_RDD : P1_CLR;
      end
      P2_RDD: begin
        indata.ce0      = 1'b1;
        indata.address0 = D_BASE + i * NL_W + j;
        next            = P2_SCL;
      end
      P2_SCL: next = P2_RD;
      P2_RD: begin
        indata.ce0      = 1'b1;
        indata.address0 = T_BASE + i * NJ_W + k;
        indata.ce1      = 1'b1;
        indata.address1 = C_BASE + k * NL_W + j;
        next            = P2_MAC;
      end
      P2_MAC: next = (k == NJ_L) ? P2_WR : P2_RD;
      P2_WR: begin
        indata.ce0      = 1'b1;
        indata.we0      = 1'b1;
        indata.address0 = D_BASE + i * NL_W + j;
        indata.d0       = acc;
        next            = (i == NI_L && j == NL_L) ? FIN : P2_RDD;
      end
      FIN: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Loop counters and accumulator; q0/q1 are consumed the cycle after the matching read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        P1_CLR: begin
          acc <= '0;
          k   <= '0;
        end
        P1_MAC: begin
          acc <= acc + ALPHA_W * indata.q0 * indata.q1;
          k   <= k + 1'b1;
        end
        P1_WR: begin
          if (j == NJ_L) begin
            j <= '0;
            i <= (i == NI_L) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        P2_SCL: begin
          acc <= BETA_W * indata.q0;
          k   <= '0;
        end
        P2_MAC: begin
          acc <= acc + indata.q0 * indata.q1;
          k   <= k + 1'b1;
        end
        P2_WR: begin
          if (j == NL_L) begin
            j <= '0;
            i <= (i == NI_L) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_2mm_core.sv
// Directed bench: a 2x2x2x2 instance against a behavioural scratchpad for results and protocol,
// plus a default-size instance for the end-to-end cycle count.
module tb_kernel_2mm_core;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       s_start, s_done, s_idle, s_ready;
  logic       b_start, b_done, b_idle, b_ready;
  logic [3:0] s_state, b_state;

  kernel_2mm_core_if #(.AW(14)) s_if ();
  kernel_2mm_core_if #(.AW(14)) b_if ();

  kernel_2mm_core #(
    .NI(2), .NK(2), .NJ(2), .NL(2), .ALPHA(32'sd3), .BETA(32'sd2), .AW(14)
  ) u_small (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(s_start), .ap_done(s_done),
    .ap_idle(s_idle), .ap_ready(s_ready), .state_dbg(s_state), .indata(s_if)
  );

  kernel_2mm_core u_big (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start), .ap_done(b_done),
    .ap_idle(b_idle), .ap_ready(b_ready), .state_dbg(b_state), .indata(b_if)
  );

  assign b_if.q0 = '0;
  assign b_if.q1 = '0;

  // small-instance scratchpad: A 0..3, B 4..7, tmp 8..11, C 12..15, D 16..19
  logic [31:0] mem [32];
  logic        tb_we   = 1'b0;
  logic [4:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [31:0] img [20];

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    if (s_if.ce0) begin
      if (s_if.we0) mem[s_if.address0[4:0]] <= s_if.d0;
      else          s_if.q0 <= mem[s_if.address0[4:0]];
    end
    if (s_if.ce1) begin
      if (s_if.we1) mem[s_if.address1[4:0]] <= s_if.d1;
      else          s_if.q1 <= mem[s_if.address1[4:0]];
    end
  end

  // per-cycle protocol monitor
  int prot_bad = 0, acc_cnt = 0, s_done_cnt = 0, b_done_cnt = 0, rdy_bad = 0;
  always @(negedge clk) begin
    if (s_if.we1 || b_if.we1 || (s_if.we0 && !s_if.ce0) || (b_if.we0 && !b_if.ce0) ||
        (s_if.ce0 && s_if.address0 >= 14'd20) || (s_if.ce1 && s_if.address1 >= 14'd20) ||
        (s_idle && (s_if.ce0 || s_if.ce1)) || (b_idle && (b_if.ce0 || b_if.ce1)))
      prot_bad++;
    if (s_if.ce0 || s_if.ce1) acc_cnt++;
    if (s_done) s_done_cnt++;
    if (b_done) b_done_cnt++;
    if (s_ready !== s_done || b_ready !== b_done) rdy_bad++;
  end

  // scoreboard
  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_region(input string tag, input int base, input int n);
    for (int x = 0; x < n; x++) check($sformatf("%s[%0d]", tag, x), mem[base + x], exp_q.pop_front());
  endtask

  // driver tasks
  task automatic mem_wr(input int a, input logic [31:0] v);
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = a[4:0];
    tb_data = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic load_img();
    for (int a = 0; a < 20; a++) mem_wr(a, img[a]);
  endtask

  task automatic run_small(output int cyc);
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1;
    while (s_done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_big(output int cyc);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (b_done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  int cyc, snap;

  initial begin
    s_start = 1'b0;
    b_start = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle", s_idle, 1);
    check("rst_ce0", s_if.ce0, 0);
    check("rst_ce1", s_if.ce1, 0);
    check("rst_done", s_done, 0);
    check("rst_ready", s_ready, 0);
    check("rst_addr0", s_if.address0, 0);
    check("rst_d0", s_if.d0, 0);
    check("rst_big_idle", b_idle, 1);

    @(negedge clk);
    rst_n = 1'b1;
    snap = acc_cnt;
    repeat (5) @(negedge clk);
    check("idle_after_rst", s_idle, 1);
    check("idle_no_access", acc_cnt - snap, 0);

    // basic: A=[[1,2],[3,4]], B=I, C=I, D=1
    img = '{1, 2, 3, 4, 1, 0, 0, 1, 32'hdead0000, 32'hdead0001, 32'hdead0002, 32'hdead0003,
            1, 0, 0, 1, 1, 1, 1, 1};
    load_img();
    snap = s_done_cnt;
    run_small(cyc);
    check("basic_cycles", cyc, 53);
    check("basic_done_once", s_done_cnt - snap, 1);
    check("basic_idle_after", s_idle, 1);
    exp_q.push_back(3);  exp_q.push_back(6);  exp_q.push_back(9);  exp_q.push_back(12);
    compare_region("basic_tmp", 8, 4);
    exp_q.push_back(5);  exp_q.push_back(8);  exp_q.push_back(11); exp_q.push_back(14);
    compare_region("basic_d", 16, 4);

    // general: A*B=[[19,22],[43,50]], C=[[1,2],[0,1]], D=[[0,1],[2,3]]
    img = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 2, 3};
    load_img();
    run_small(cyc);
    exp_q.push_back(57);  exp_q.push_back(66);  exp_q.push_back(129); exp_q.push_back(150);
    compare_region("gen_tmp", 8, 4);
    exp_q.push_back(57);  exp_q.push_back(182); exp_q.push_back(133); exp_q.push_back(414);
    compare_region("gen_d", 16, 4);

    // wrap-around in both phases
    img = '{32'h40000000, 0, 0, 32'h7fffffff, 32'h40000000, 0, 0, 2, 5, 5, 5, 5,
            0, 0, 0, 0, 32'hffffffff, 7, 32'h80000000, 0};
    load_img();
    run_small(cyc);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'hfffffffa);
    compare_region("ovf_tmp", 8, 4);
    exp_q.push_back(32'hfffffffe); exp_q.push_back(14); exp_q.push_back(0); exp_q.push_back(0);
    compare_region("ovf_d", 16, 4);

    // reset in phase 2, then reload D and rerun
    img = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 2, 3};
    load_img();
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (34) @(negedge clk);
    check("mid_busy", s_idle, 0);
    check("mid_partial_d00", mem[16], 57);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ce0", s_if.ce0, 0);
    check("mid_rst_ce1", s_if.ce1, 0);
    check("mid_rst_idle", s_idle, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_wr(16, 0); mem_wr(17, 1); mem_wr(18, 2); mem_wr(19, 3);
    snap = s_done_cnt;
    run_small(cyc);
    check("restart_cycles", cyc, 53);
    check("restart_done_once", s_done_cnt - snap, 1);
    exp_q.push_back(57);  exp_q.push_back(182); exp_q.push_back(133); exp_q.push_back(414);
    compare_region("restart_d", 16, 4);

    // default-size latency
    snap = b_done_cnt;
    run_big(cyc);
    check("big_cycles", cyc, 17665);
    check("big_done_once", b_done_cnt - snap, 1);
    check("big_idle_after", b_idle, 1);

    check("protocol", prot_bad, 0);
    check("ready_eq_done", rdy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
